// File: rtl/btn_press_filter.sv
// Player push-button conditioning: two-flop synchroniser, per-button debounce,
// and a press-event FSM that emits one single-cycle event per clean single-button press.
module btn_press_filter #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    input  logic             enable,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             was_some_btn_pressed,
    output logic [1:0]       btn_code,
    output logic             multi_press,
    output logic [N_BTN-1:0] btn_level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_IDLE,
        S_HELD
    } state_t;

    logic [N_BTN-1:0] w_raw;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [N_BTN-1:0] r_level;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_BTN-1:0] r_pulse;
    logic [N_BTN-1:0] w_pulse_nxt;
    logic             r_was;
    logic             r_multi;
    logic             w_multi_nxt;
    logic [1:0]       r_code;
    logic [1:0]       w_code_nxt;
    logic [1:0]       w_idx;
    logic             w_onehot;

    assign w_raw = BTN_ACTIVE_LOW ? ~btn : btn;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level flips after DEBOUNCE_CYCLES consecutive mismatching samples; any match restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_level[i] <= ~r_level[i];
                    r_cnt[i]   <= '0;
                end else if (r_cnt[i] != CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_onehot = (r_level != '0) && ((r_level & (r_level - 1'b1)) == '0);

    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (r_level[i]) begin
                w_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Any press seen in IDLE moves to HELD, so each physical press is judged exactly once.
    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = '0;
        w_multi_nxt = 1'b0;
        w_code_nxt  = r_code;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_state_nxt = S_HELD;
                    if (enable) begin
                        if (w_onehot) begin
                            w_pulse_nxt = r_level;
                            w_code_nxt  = w_idx;
                        end else begin
                            w_multi_nxt = 1'b1;
                        end
                    end
                end
            end
            S_HELD: begin
                if (r_level == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pulse <= '0;
            r_was   <= 1'b0;
            r_multi <= 1'b0;
            r_code  <= '0;
        end else begin
            r_pulse <= w_pulse_nxt;
            r_was   <= |w_pulse_nxt;
            r_multi <= w_multi_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign btn_pulse            = r_pulse;
    assign was_some_btn_pressed = r_was;
    assign multi_press          = r_multi;
    assign btn_code             = r_code;
    assign btn_level            = r_level;

endmodule

// File: doc/btn_press_filter.md
# btn_press_filter

Upstream conditioning stage for the Genius player inputs. Synchronises the three raw push-buttons to `clock`, debounces each one independently, and turns a clean single-button press into exactly one single-cycle event (one-hot pulse plus 2-bit code). The Genius FSM consumes these events in its input-receiving state. Multi-button presses and presses made while input is disabled are suppressed, so each physical press yields at most one event.

## Interface
- `N_BTN`, 3: number of buttons; fixed at 3 for Genius, and `btn_code` is sized for it.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range ≥1.
- `BTN_ACTIVE_LOW`, 1: 1 means a raw `btn` bit is 0 while pressed (board KEYs); 0 means active-high.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn`  in  3  raw, asynchronous push-button levels.
- `enable`  in  1  1 allows a press to generate an event; driven by the consumer while it awaits input.
- `btn_pulse`  out  3  one-hot, one-cycle pulse for an accepted press.
- `was_some_btn_pressed`  out  1  OR of `btn_pulse`; same cycle.
- `btn_code`  out  2  index (0..2) of the last accepted button; held until the next accepted press.
- `multi_press`  out  1  one-cycle pulse when a press is rejected because two or more buttons are down.
- `btn_level`  out  3  debounced pressed levels, active-high.

## Operation
- Polarity: the raw input is first normalised to pressed=1 when `BTN_ACTIVE_LOW`=1. All internal state and outputs are active-high.
- Synchroniser: two flops per button. Reset loads released (0).
- Debounce, per button:
  - The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - Each cycle where the synchronised level differs from `btn_level[i]`, the counter increments.
  - On any cycle where they match, the counter clears to 0.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the levels still differ, `btn_level[i]` flips and the counter clears.
  - The counter never wraps.
- Event FSM: states IDLE, HELD. Reset state is IDLE.
- IDLE, `btn_level`==0: stay.
- IDLE, `btn_level`!=0, `enable`=1, exactly one bit set:
  - Register `btn_pulse`=`btn_level` and `btn_code`=index for one cycle.
  - Go to HELD.
- IDLE, `btn_level`!=0, `enable`=1, two or more bits set: pulse `multi_press`, leave `btn_code` unchanged, go to HELD.
- IDLE, `btn_level`!=0, `enable`=0: go to HELD silently. A press held across `enable` rising never fires.
- HELD: stay until `btn_level`==0, then go to IDLE. Extra buttons pressed while in HELD never fire an event.
- `btn_pulse`, `was_some_btn_pressed` and `multi_press` are registered and high for exactly one cycle per event.

## Timing
- Reset (asynchronous, active-low): `btn_pulse`=0, `was_some_btn_pressed`=0, `multi_press`=0, `btn_code`=0, `btn_level`=0. Synchroniser flops and counters are 0 and the FSM is IDLE. Reset takes effect immediately, without a clock edge.
- Reset asserted mid-press: the press is discarded. After release of `reset`, a still-held button must first debounce as a new press, taking the full latency below.
- Latency: the raw press is first sampled at edge E1. Then:
  - `btn_level` rises after edge E1+1+`DEBOUNCE_CYCLES`.
  - `btn_pulse` is high during the cycle after edge E1+2+`DEBOUNCE_CYCLES` (that is, `DEBOUNCE_CYCLES`+3 edges from the first sample).
- Release latency: `btn_level` falls `DEBOUNCE_CYCLES`+2 edges after the first released sample. The FSM returns to IDLE one edge later.
- Glitch rejection: a mismatch shorter than `DEBOUNCE_CYCLES` cycles never changes `btn_level`.
- Simultaneous debounce completion on two buttons in the same cycle counts as a multi-press.
- Minimum spacing between two accepted events is 2×(`DEBOUNCE_CYCLES`+2)+1 cycles: press, release, press.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `BTN_ACTIVE_LOW`=1.
- **Clean press:** `enable`=1; `btn` goes 3'b111→3'b101 and is held for 20 cycles. Required: `btn_pulse`=3'b010, `was_some_btn_pressed`=1 and `btn_code`=1, each for exactly one cycle, 7 edges after the first sample. No second pulse while held or on release.
- **Bounce rejection:** toggle `btn[0]` pressed/released every 2 cycles for 12 cycles, then hold it pressed. Required: a single pulse with `btn_code`=0, 7 edges after the final stable press begins. `btn_level` stays 0 during the toggling.
- **Multi-press:** buttons 0 and 2 pressed on the same cycle. Required: one `multi_press` pulse, `btn_pulse` stays 0, `btn_code` keeps its previous value. Afterwards, releasing both and then pressing button 2 alone gives `btn_code`=2.
- **Enable gating:** press button 1 with `enable`=0, raise `enable` while it is still held, then release. Required: no pulse. The next press of button 1 with `enable`=1 gives exactly one pulse.
- **Async reset mid-press:** assert `reset`=0 between edges while button 2 is debounced and held. Required: all outputs 0 immediately. After `reset`=1 with the button still held, a pulse with `btn_code`=2 arrives 7 edges later.
- **Chord during hold:** hold button 0 (one pulse), press button 1 while still in HELD. Required: no pulse and no `multi_press`. A pulse for button 1 comes only after everything is released and button 1 is pressed again.
